// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared defaults, zone mapping and stage control record for approx_mult_pipe
package approx_mult_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ZONES = 4;
  localparam int DEF_APX_COLS = 4;
  typedef struct packed {
    logic valid;
    logic approx;
  } stage_ctl_t;
  function automatic int zone_cols(input int width, input int zones);
    return (2 * width - 1 + zones - 1) / zones;
  endfunction
  function automatic int zone_of(input int col, input int width, input int zones);
    int z;
    z = col / zone_cols(width, zones);
    return (z < zones - 1) ? z : zones - 1;
  endfunction
endpackage

// File: rtl/approx_pp_mask.sv
// approx_pp_mask: zone-gated partial-product matrix, pp[i][j] = a[j] & b[i] unless its zone is truncated
module approx_pp_mask
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_ZONES = DEF_ZONES
) (
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [NUM_ZONES-1:0]         trunc,
  output logic [WIDTH-1:0][WIDTH-1:0]  pp
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
      assign pp[i][j] = a[j] & b[i] & ~trunc[zone_of(i + j, WIDTH, NUM_ZONES)];
    end
  end
endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage valid/ready zone-truncated multiplier with optional OR-compressed low columns
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_ZONES = DEF_ZONES,
  parameter int APX_COLS = DEF_APX_COLS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [NUM_ZONES-1:0] in_trunc,
  input  logic                 in_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod
);
  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] LO_MASK = {PW{1'b1}} >> (PW - APX_COLS);
  logic [WIDTH-1:0][WIDTH-1:0] pp, s1_pp;
  stage_ctl_t s1, s2;
  logic [PW-1:0] sh, row_x, row_y, low_or, s2_x, s2_y, s2_lo;
  logic stall;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  approx_pp_mask #(.WIDTH(WIDTH), .NUM_ZONES(NUM_ZONES)) u_mask (
    .a(in_a),
    .b(in_b),
    .trunc(in_trunc),
    .pp(pp)
  );
  always_comb begin
    sh = '0;
    row_x = '0;
    row_y = '0;
    low_or = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sh = PW'(s1_pp[i]) << i;
      low_or = low_or | (sh & LO_MASK);
      sh = s1.approx ? sh & ~LO_MASK : sh;
      row_x = (i % 2 == 0) ? row_x + sh : row_x;
      row_y = (i % 2 == 1) ? row_y + sh : row_y;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s1_pp <= '0;
      s2_x <= '0;
      s2_y <= '0;
      s2_lo <= '0;
      out_valid <= 1'b0;
      out_prod <= '0;
    end else if (!stall) begin
      s1 <= '{valid: in_valid, approx: in_approx};
      s1_pp <= pp;
      s2 <= s1;
      s2_x <= row_x;
      s2_y <= row_y;
      s2_lo <= low_or;
      out_valid <= s2.valid;
      if (s2.valid) out_prod <= (s2_x + s2_y) | (s2.approx ? s2_lo : '0);
    end
  end
endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe: directed self-checking bench for approx_mult_pipe at default parameters
module tb_approx_mult_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_approx, out_valid, out_ready;
  logic [7:0] in_a, in_b;
  logic [3:0] in_trunc;
  logic [15:0] out_prod;
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] va[8], vb[8];
  logic [3:0] vt[8];
  logic vx[8];
  logic [15:0] ve[8];
  approx_mult_pipe dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_trunc(in_trunc),
    .in_approx(in_approx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod(out_prod)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                         input logic x, input logic [15:0] exp, input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_trunc = t;
    in_approx = x;
    @(negedge clk);
    in_valid = 1'b0;
    in_trunc = ~t;
    in_approx = ~x;
    @(negedge clk);
    check({tag, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_prod"}, out_prod, exp);
  endtask
  task automatic run_stream(input int n, input int st_lo, input int st_hi, input string tag);
    int sent = 0;
    int got = 0;
    logic held_v = 1'b0;
    logic [15:0] held = '0;
    for (int c = 0; c < 40 && got < n; c++) begin
      @(negedge clk);
      out_ready = !(c >= st_lo && c <= st_hi);
      #1;
      if (out_valid && out_ready) begin
        check({tag, "_prod"}, out_prod, ve[got]);
        got++;
      end
      if (out_valid && !out_ready) begin
        check({tag, "_inrdy"}, in_ready, 1'b0);
        if (held_v) check({tag, "_hold"}, out_prod, held);
        held = out_prod;
        held_v = 1'b1;
      end else held_v = 1'b0;
      if (sent < n && in_ready) begin
        in_valid = 1'b1;
        in_a = va[sent];
        in_b = vb[sent];
        in_trunc = vt[sent];
        in_approx = vx[sent];
        sent++;
      end else begin
        in_valid = 1'b0;
        in_trunc = 4'hF;
        in_approx = 1'b1;
      end
    end
    check({tag, "_count"}, got, n);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    in_trunc = '0;
    in_approx = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_prod", out_prod, 16'd0);
    check("rst_inrdy", in_ready, 1'b1);
    rst = 1'b0;
    run_one(8'd255, 8'd255, 4'b0000, 1'b0, 16'd65025, "exact_max");
    run_one(8'd255, 8'd255, 4'b0001, 1'b0, 16'd64976, "trunc_z0");
    run_one(8'd255, 8'd255, 4'b0000, 1'b1, 16'hFDDF, "approx_max");
    run_one(8'd255, 8'd255, 4'b1000, 1'b0, 16'd19969, "trunc_z3");
    run_one(8'd255, 8'd255, 4'b1111, 1'b1, 16'd0, "trunc_all");
    run_one(8'd3, 8'd3, 4'b0000, 1'b1, 16'd7, "approx_or");
    run_one(8'd200, 8'd13, 4'b0000, 1'b0, 16'd2600, "exact_mix");
    for (int k = 0; k < 6; k++) begin
      va[k] = 8'(k + 1);
      vb[k] = 8'(k + 2);
      vt[k] = 4'b0000;
      vx[k] = 1'b0;
    end
    ve = '{16'd2, 16'd6, 16'd12, 16'd20, 16'd30, 16'd42, 16'd0, 16'd0};
    run_stream(6, 4, 7, "bp");
    for (int k = 0; k < 4; k++) begin
      va[k] = 8'd200;
      vb[k] = 8'd200;
      vt[k] = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      vx[k] = 1'b0;
    end
    ve = '{16'd0, 16'd40000, 16'd0, 16'd40000, 16'd0, 16'd0, 16'd0, 16'd0};
    run_stream(4, -1, -1, "cfg");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = 8'(k + 9);
      in_b = 8'd11;
      in_trunc = 4'b0000;
      in_approx = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_prod", out_prod, 16'd0);
    check("midrst_inrdy", in_ready, 1'b1);
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_ghost", seen, 0);
    run_one(8'd3, 8'd5, 4'b0000, 1'b0, 16'd15, "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
